// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: Fibonacci XNOR LFSR pseudo-random source with a
// valid/ready output stream, run-time seed load, full-period detection
// (gen_done) and automatic replacement of the all-ones lock-up seed.
// Optional feature macro: LFSR_PERIOD_CNT_EN builds the period counter;
// when undefined period_cnt is tied to zero.
module lfsr_stream_gen #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_en,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             enable,
  input  logic             rand_ready,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid,
  output logic             gen_done,
  output logic             lockup,
  output logic [WIDTH-1:0] period_cnt
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             lock_q, lock_d;

  logic             fb;
  logic [WIDTH-1:0] nxt;
  logic             advance;
  logic             seed_bad;
  logic             wrap;

  // Feedback, step qualification and wrap detection
  always_comb begin
    fb       = ~^(state_q & TAPS);
    nxt      = {state_q[WIDTH-2:0], fb};
    advance  = enable & ~seed_en & (~vld_q | rand_ready);
    seed_bad = &seed_data;
    wrap     = (nxt == seed_q);
  end

  // Next-state: seed load beats stepping; otherwise step or drain/hold
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    out_d   = out_q;
    vld_d   = vld_q & ~rand_ready;
    done_d  = 1'b0;
    lock_d  = 1'b0;
    if (seed_en) begin
      // all-ones would stall an XNOR LFSR forever, so swap in the reset seed
      state_d = seed_bad ? RESET_SEED : seed_data;
      seed_d  = seed_bad ? RESET_SEED : seed_data;
      lock_d  = seed_bad;
      vld_d   = 1'b0;
    end else if (advance) begin
      state_d = nxt;
      out_d   = nxt;
      vld_d   = 1'b1;
      done_d  = wrap;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
      seed_q  <= RESET_SEED;
      out_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      lock_q  <= lock_d;
    end
  end

  assign rand_out   = out_q;
  assign rand_valid = vld_q;
  assign gen_done   = done_q;
  assign lockup     = lock_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] period_q;

  // Count advances since the last seed/wrap; latch the count at each wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      period_q <= '0;
    end else if (seed_en) begin
      step_q <= '0;
    end else if (advance) begin
      if (wrap) begin
        period_q <= step_q + WIDTH'(1);
        step_q   <= '0;
      end else begin
        step_q <= step_q + WIDTH'(1);
      end
    end
  end

  assign period_cnt = period_q;
`else
  assign period_cnt = '0;
`endif

endmodule
